// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: IF, LSU and memory-side
// signals of the shared memory port arbiter
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  localparam int STRB_W = DATA_W / 8;

  logic              if_i_req;
  logic [ADDR_W-1:0] if_i_addr;
  logic              if_i_cancel;
  logic              if_o_done;
  logic [DATA_W-1:0] if_o_rdata;

  logic              lsu_i_req;
  logic              lsu_i_we;
  logic [ADDR_W-1:0] lsu_i_addr;
  logic [DATA_W-1:0] lsu_i_wdata;
  logic [STRB_W-1:0] lsu_i_wstrb;
  logic              lsu_o_done;
  logic [DATA_W-1:0] lsu_o_rdata;

  logic              mem_o_valid;
  logic              mem_o_we;
  logic [ADDR_W-1:0] mem_o_addr;
  logic [DATA_W-1:0] mem_o_wdata;
  logic [STRB_W-1:0] mem_o_wstrb;
  logic              mem_i_ready;
  logic              mem_i_rvalid;
  logic [DATA_W-1:0] mem_i_rdata;

  logic              arb_o_if_stall;
  logic              arb_o_lsu_stall;

  modport master (
    input  if_i_req,
    input  if_i_addr,
    input  if_i_cancel,
    output if_o_done,
    output if_o_rdata,
    input  lsu_i_req,
    input  lsu_i_we,
    input  lsu_i_addr,
    input  lsu_i_wdata,
    input  lsu_i_wstrb,
    output lsu_o_done,
    output lsu_o_rdata,
    output mem_o_valid,
    output mem_o_we,
    output mem_o_addr,
    output mem_o_wdata,
    output mem_o_wstrb,
    input  mem_i_ready,
    input  mem_i_rvalid,
    input  mem_i_rdata,
    output arb_o_if_stall,
    output arb_o_lsu_stall
  );

  modport slave (
    output if_i_req,
    output if_i_addr,
    output if_i_cancel,
    input  if_o_done,
    input  if_o_rdata,
    output lsu_i_req,
    output lsu_i_we,
    output lsu_i_addr,
    output lsu_i_wdata,
    output lsu_i_wstrb,
    input  lsu_o_done,
    input  lsu_o_rdata,
    input  mem_o_valid,
    input  mem_o_we,
    input  mem_o_addr,
    input  mem_o_wdata,
    input  mem_o_wstrb,
    output mem_i_ready,
    output mem_i_rvalid,
    output mem_i_rdata,
    input  arb_o_if_stall,
    input  arb_o_lsu_stall
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one memory port shared by IF and LSU,
// single outstanding transaction, LSU first with IF starvation guard
module mem_port_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input logic clk,
  input logic rst_n,
  mem_port_arbiter_if.master bus
);
  localparam int STRB_W = DATA_W / 8;
  localparam int CNT_W  = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } state_t;

  state_t state_q, state_d;

  logic              owner_lsu_q;
  logic              drop_q;
  logic [CNT_W-1:0]  starve_q;
  logic              req_we_q;
  logic [ADDR_W-1:0] req_addr_q;
  logic [DATA_W-1:0] req_wdata_q;
  logic [STRB_W-1:0] req_wstrb_q;

  logic if_cand;
  logic starved;
  logic grant_lsu;
  logic grant_if;
  logic grant;

  // a fetch cancelled in the same cycle never competes
  always_comb begin
    if_cand   = bus.if_i_req & ~bus.if_i_cancel;
    starved   = starve_q == CNT_W'(STARVE_LIMIT);
    grant_lsu = bus.lsu_i_req & ~(starved & if_cand);
    grant_if  = if_cand & ~grant_lsu;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d         = state_q;
    grant           = 1'b0;
    bus.mem_o_valid = 1'b0;
    bus.if_o_done   = 1'b0;
    bus.lsu_o_done  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_lsu | grant_if) begin
          grant   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        bus.mem_o_valid = 1'b1;
        if (bus.mem_i_ready) state_d = WAIT;
      end
      WAIT: begin
        if (bus.mem_i_rvalid) begin
          state_d        = IDLE;
          bus.lsu_o_done = owner_lsu_q;
          bus.if_o_done  = ~owner_lsu_q & ~drop_q
                         & ~bus.if_i_cancel;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_lsu_q <= 1'b0;
      req_we_q    <= 1'b0;
      req_addr_q  <= '0;
      req_wdata_q <= '0;
      req_wstrb_q <= '0;
    end else if (grant) begin
      owner_lsu_q <= grant_lsu;
      unique case (1'b1)
        grant_lsu: begin
          req_we_q    <= bus.lsu_i_we;
          req_addr_q  <= bus.lsu_i_addr;
          req_wdata_q <= bus.lsu_i_wdata;
          req_wstrb_q <= bus.lsu_i_we ?
                         bus.lsu_i_wstrb : '0;
        end
        grant_if: begin
          req_we_q    <= 1'b0;
          req_addr_q  <= bus.if_i_addr;
          req_wdata_q <= '0;
          req_wstrb_q <= '0;
        end
        default: ;
      endcase
    end
  end

  // counts LSU wins while a fetch was left waiting
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (grant) begin
      if (grant_if || !bus.if_i_req)
        starve_q <= '0;
      else if (!starved)
        starve_q <= starve_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_q <= 1'b0;
    end else if (state_q == WAIT
                 && bus.mem_i_rvalid) begin
      drop_q <= 1'b0;
    end else if (state_q != IDLE
                 && !owner_lsu_q
                 && bus.if_i_cancel) begin
      drop_q <= 1'b1;
    end
  end

  assign bus.mem_o_we    = req_we_q;
  assign bus.mem_o_addr  = req_addr_q;
  assign bus.mem_o_wdata = req_wdata_q;
  assign bus.mem_o_wstrb = req_wstrb_q;

  assign bus.if_o_rdata  = bus.mem_i_rdata;
  assign bus.lsu_o_rdata = bus.mem_i_rdata;

  assign bus.arb_o_if_stall  = bus.if_i_req
                             & ~bus.if_o_done;
  assign bus.arb_o_lsu_stall = bus.lsu_i_req
                             & ~bus.lsu_o_done;
endmodule
